// File: rtl/change_dispenser.sv
// Change dispenser: computes credit - price and pays it out one coin at a
// time, largest denomination first, over a coin_valid/coin_ack handshake.
// Ports: clk, reset (sync, active-low), start, credit[7:0], price[7:0],
//   coin_ack in; coin_valid, coin_sel[1:0], busy, done, err_code[1:0],
//   change_left[7:0], coins_paid[3:0] out (all registered).
module change_dispenser #(
  parameter int unsigned DEN_HI      = 10,
  parameter int unsigned DEN_MID     = 5,
  parameter int unsigned DEN_LO      = 1,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] credit,
  input  logic [7:0] price,
  input  logic       coin_ack,
  output logic       coin_valid,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  output logic [7:0] change_left,
  output logic [3:0] coins_paid
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PICK, S_WAIT, S_GAP, S_DONE
  } state_t;

  localparam logic [7:0] HI8     = 8'(DEN_HI);
  localparam logic [7:0] MID8    = 8'(DEN_MID);
  localparam logic [7:0] LO8     = 8'(DEN_LO);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] GP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_q;
  logic [7:0] credit_q;
  logic [7:0] price_q;
  logic [7:0] cnt_q;
  logic       pick_ph_q;
  logic       valid_q;
  logic [1:0] sel_q;
  logic       busy_q;
  logic       done_q;
  logic [1:0] err_q;
  logic [7:0] left_q;
  logic [3:0] paid_q;

  logic [1:0] pick_sel;
  logic [7:0] den_cur;

  always_comb begin
    pick_sel = 2'd0;
    priority case (1'b1)
      (left_q >= HI8):  pick_sel = 2'd2;
      (left_q >= MID8): pick_sel = 2'd1;
      default:          pick_sel = 2'd0;
    endcase
  end

  always_comb begin
    den_cur = LO8;
    unique case (sel_q)
      2'd2:    den_cur = HI8;
      2'd1:    den_cur = MID8;
      default: den_cur = LO8;
    endcase
  end

  // PICK takes two cycles: the first registers coin_sel, the
  // second presents the coin, so coin_sel is stable before valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      credit_q  <= '0;
      price_q   <= '0;
      cnt_q     <= '0;
      pick_ph_q <= 1'b0;
      valid_q   <= 1'b0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      left_q    <= '0;
      paid_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            credit_q <= credit;
            price_q  <= price;
            err_q    <= 2'd0;
            paid_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          pick_ph_q <= 1'b0;
          if (credit_q < price_q) begin
            err_q   <= 2'd1;
            left_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (credit_q == price_q) begin
            left_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            left_q  <= credit_q - price_q;
            state_q <= S_PICK;
          end
        end
        S_PICK: begin
          if (!pick_ph_q) begin
            sel_q     <= pick_sel;
            pick_ph_q <= 1'b1;
          end else begin
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // ack is checked first so it wins over an expiring timer
          if (coin_ack) begin
            valid_q <= 1'b0;
            left_q  <= left_q - den_cur;
            if (paid_q != 4'hF) paid_q <= paid_q + 4'd1;
            cnt_q <= '0;
            if (left_q == den_cur) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_GAP;
            end
          end else if (cnt_q == TO_LAST) begin
            valid_q <= 1'b0;
            err_q   <= 2'd2;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GP_LAST) begin
            pick_ph_q <= 1'b0;
            state_q   <= S_PICK;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign coin_valid  = valid_q;
  assign coin_sel    = sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_code    = err_q;
  assign change_left = left_q;
  assign coins_paid  = paid_q;

endmodule
